// File: rtl/dcache_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_mem_ctrl_if
// Description : Data-cache side requests (refill, store) and RAM port B
//               signals of the data-cache memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 20
);
  // Refill requester
  logic                  refill_req_i;
  logic [ADDR_WIDTH-1:0] refill_addr_i;
  logic                  refill_gnt_o;
  logic                  refill_valid_o;
  logic [127:0]          refill_line_o;
  // Store requester
  logic                  store_req_i;
  logic [ADDR_WIDTH-1:0] store_addr_i;
  logic [31:0]           store_wdata_i;
  logic [3:0]            store_be_i;
  logic                  store_gnt_o;
  // Status
  logic                  busy_o;
  // RAM port B
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_rdata_i;

  // Requesters and RAM as seen from outside the controller
  modport master (
    output refill_req_i, refill_addr_i,
    output store_req_i, store_addr_i, store_wdata_i, store_be_i,
    output mem_rdata_i,
    input  refill_gnt_o, refill_valid_o, refill_line_o,
    input  store_gnt_o, busy_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  // The controller itself
  modport slave (
    input  refill_req_i, refill_addr_i,
    input  store_req_i, store_addr_i, store_wdata_i, store_be_i,
    input  mem_rdata_i,
    output refill_gnt_o, refill_valid_o, refill_line_o,
    output store_gnt_o, busy_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface
`default_nettype wire

// File: rtl/dcache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_mem_ctrl
// Description : Drives RAM port B for the data cache. Serves 4-word line
//               refills (assembled into a 128-bit line) and single-word
//               write-through stores, arbitrated round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_mem_ctrl #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic              clk,
  input  logic              rst,
  dcache_mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_DONE = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:4]   base_q, base_d;
  logic [ADDR_WIDTH-1:2]   st_addr_q, st_addr_d;
  logic [31:0]             st_wdata_q, st_wdata_d;
  logic [3:0]              st_be_q, st_be_d;
  logic                    last_was_store_q, last_was_store_d;
  logic [127:0]            line_q, line_d;

  logic                    refill_gnt;
  logic                    store_gnt;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_be;

  // Low address bits are don't-care: lines are 16-byte, stores word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.refill_addr_i[3:0], bus.store_addr_i[1:0]};

  // State register and latched request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 2'd0;
      base_q           <= '0;
      st_addr_q        <= '0;
      st_wdata_q       <= 32'd0;
      st_be_q          <= 4'd0;
      last_was_store_q <= 1'b0;
      line_q           <= 128'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      base_q           <= base_d;
      st_addr_q        <= st_addr_d;
      st_wdata_q       <= st_wdata_d;
      st_be_q          <= st_be_d;
      last_was_store_q <= last_was_store_d;
      line_q           <= line_d;
    end
  end

  // Arbitration, next state, read capture and RAM port drive
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    st_addr_d        = st_addr_q;
    st_wdata_d       = st_wdata_q;
    st_be_d          = st_be_q;
    last_was_store_d = last_was_store_q;
    line_d           = line_q;
    refill_gnt       = 1'b0;
    store_gnt        = 1'b0;
    mem_en           = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = 32'd0;
    mem_be           = 4'd0;

    case (state_q)
      S_IDLE: begin
        // On a tie the store wins unless the previous grant was a store.
        if (bus.store_req_i && (!bus.refill_req_i || !last_was_store_q)) begin
          store_gnt        = 1'b1;
          st_addr_d        = bus.store_addr_i[ADDR_WIDTH-1:2];
          st_wdata_d       = bus.store_wdata_i;
          st_be_d          = bus.store_be_i;
          last_was_store_d = 1'b1;
          state_d          = S_WR;
        end else if (bus.refill_req_i) begin
          refill_gnt       = 1'b1;
          base_d           = bus.refill_addr_i[ADDR_WIDTH-1:4];
          cnt_d            = 2'd0;
          last_was_store_d = 1'b0;
          state_d          = S_RD;
        end
      end

      S_RD: begin
        mem_en   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = {base_q, cnt_q, 2'b00};
        // Data for the read issued last cycle is on mem_rdata_i now.
        case (cnt_q)
          2'd1:    line_d[31:0]  = bus.mem_rdata_i;
          2'd2:    line_d[63:32] = bus.mem_rdata_i;
          2'd3:    line_d[95:64] = bus.mem_rdata_i;
          default: ;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_CAP;
        end
      end

      S_CAP: begin
        line_d[127:96] = bus.mem_rdata_i;
        state_d        = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {st_addr_q, 2'b00};
        mem_wdata = st_wdata_q;
        mem_be    = st_be_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.refill_gnt_o   = refill_gnt;
  assign bus.store_gnt_o    = store_gnt;
  assign bus.refill_valid_o = (state_q == S_DONE);
  assign bus.refill_line_o  = line_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.mem_en_o       = mem_en;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.mem_be_o       = mem_be;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_mem_ctrl
// Description : Self-checking bench for dcache_mem_ctrl with a RAM port B
//               model and a refill-line scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_ctrl;
  localparam int AW    = 20;
  localparam int WORDS = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  dcache_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dcache_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];
  logic [31:0]  ref_mem [int unsigned];
  logic [31:0]  ram [0:WORDS-1];

  function automatic logic [31:0] init_val(input logic [17:0] i);
    case (i)
      18'h40:  return 32'h11111111;
      18'h41:  return 32'h22222222;
      18'h42:  return 32'h33333333;
      18'h43:  return 32'h44444444;
      default: return {i[15:0] ^ 16'h5A5A, i[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // RAM port B model: 1-cycle registered read, byte-enabled write
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_val(i[17:0]);
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o)
        ram[bus.mem_addr_o[AW-1:2]] <= merge(ram[bus.mem_addr_o[AW-1:2]],
                                             bus.mem_wdata_o, bus.mem_be_o);
      bus.mem_rdata_i <= ram[bus.mem_addr_o[AW-1:2]];
    end
  end

  // Scoreboard: every refill_valid_o pulse pops one expected line
  always @(negedge clk) begin
    if (!rst && bus.refill_valid_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_valid line=%h want=no pulse", bus.refill_line_o);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (bus.refill_line_o !== e) begin
          bad++;
          $display("FAIL sb_line got=%h want=%h", bus.refill_line_o, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_rd(input logic [17:0] idx);
    if (ref_mem.exists(int'(idx))) return ref_mem[int'(idx)];
    return init_val(idx);
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    ref_mem[int'(a[AW-1:2])] = merge(ref_rd(a[AW-1:2]), d, be);
  endtask

  function automatic logic [127:0] exp_line(input logic [AW-1:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = ref_rd({a[AW-1:4], 2'(k)});
    return l;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      samp();
      if (bus.busy_o === 1'b0) break;
      tick();
    end
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle busy=%b want=0", bus.busy_o);
    end
  endtask

  // One refill with no competing request; checks every cycle of the sequence
  task automatic do_refill(input logic [AW-1:0] a, output logic [127:0] got);
    logic [AW-1:0] ea;
    tick();
    bus.refill_addr_i = a;
    bus.refill_req_i  = 1'b1;
    samp();
    total++;
    if (bus.refill_gnt_o !== 1'b1 || bus.store_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL rf_gnt got=%b/%b want=1/0", bus.refill_gnt_o, bus.store_gnt_o);
    end
    exp_q.push_back(exp_line(a));
    tick();
    bus.refill_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      samp();
      ea = {a[AW-1:4], 4'h0} + AW'(4 * k);
      total++;
      if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_be_o !== 4'hF ||
          bus.mem_addr_o !== ea || bus.mem_wdata_o !== 32'd0 || bus.refill_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL rf_rd k=%0d en=%b we=%b be=%h addr=%h wd=%h v=%b want 1 0 f %h 0 0",
                 k, bus.mem_en_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
                 bus.mem_wdata_o, bus.refill_valid_o, ea);
      end
      tick();
    end
    samp();
    total++;
    if (bus.mem_en_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.refill_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rf_cap en=%b busy=%b v=%b want 0 1 0", bus.mem_en_o, bus.busy_o,
               bus.refill_valid_o);
    end
    tick();
    samp();
    total++;
    if (bus.refill_valid_o !== 1'b1 || bus.mem_en_o !== 1'b0 || bus.refill_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL rf_done v=%b en=%b gnt=%b want 1 0 0", bus.refill_valid_o,
               bus.mem_en_o, bus.refill_gnt_o);
    end
    got = bus.refill_line_o;
    tick();
    samp();
    total++;
    if (bus.busy_o !== 1'b0 || bus.refill_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rf_after busy=%b v=%b want 0 0", bus.busy_o, bus.refill_valid_o);
    end
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    tick();
    bus.store_addr_i  = a;
    bus.store_wdata_i = d;
    bus.store_be_i    = be;
    bus.store_req_i   = 1'b1;
    samp();
    total++;
    if (bus.store_gnt_o !== 1'b1 || bus.refill_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL st_gnt got=%b/%b want=1/0", bus.store_gnt_o, bus.refill_gnt_o);
    end
    ref_write(a, d, be);
    tick();
    bus.store_req_i = 1'b0;
    samp();
    total++;
    if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== {a[AW-1:2], 2'b00} ||
        bus.mem_wdata_o !== d || bus.mem_be_o !== be || bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL st_wr en=%b we=%b addr=%h wd=%h be=%h busy=%b want 1 1 %h %h %h 1",
               bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o,
               bus.busy_o, {a[AW-1:2], 2'b00}, d, be);
    end
    tick();
    samp();
    total++;
    if (bus.busy_o !== 1'b0 || bus.mem_en_o !== 1'b0) begin
      bad++;
      $display("FAIL st_after busy=%b en=%b want 0 0", bus.busy_o, bus.mem_en_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ram_init = 1'b1;
    tick();
    ram_init = 1'b0;
    tick();
    samp();
    total++;
    if (bus.busy_o !== 1'b0 || bus.mem_en_o !== 1'b0 || bus.mem_we_o !== 1'b0 ||
        bus.mem_addr_o !== '0 || bus.mem_wdata_o !== 32'd0 || bus.mem_be_o !== 4'd0 ||
        bus.refill_valid_o !== 1'b0 || bus.refill_line_o !== 128'd0 ||
        bus.refill_gnt_o !== 1'b0 || bus.store_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state busy=%b en=%b we=%b addr=%h wd=%h be=%h v=%b line=%h want all 0",
               bus.busy_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
               bus.mem_be_o, bus.refill_valid_o, bus.refill_line_o);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_refill();
    logic [127:0] got;
    do_refill(20'h00104, got);
    total++;
    if (got !== 128'h44444444_33333333_22222222_11111111) begin
      bad++;
      $display("FAIL refill_line got=%h want=44444444333333332222222211111111", got);
    end
  endtask

  task automatic test_store();
    logic [127:0] got;
    do_store(20'h00209, 32'hDEADBEEF, 4'b0011);
    do_store(20'h00204, 32'hFFFFFFFF, 4'b0000);
    do_refill(20'h00200, got);
    total++;
    if (got[95:64] !== 32'h5AD8BEEF) begin
      bad++;
      $display("FAIL store_merge got=%h want=5ad8beef", got[95:64]);
    end
    total++;
    if (got[63:32] !== 32'h5ADB0081) begin
      bad++;
      $display("FAIL store_be0 got=%h want=5adb0081", got[63:32]);
    end
  endtask

  task automatic test_round_robin();
    logic seq [8];
    int g = 0;
    int n = 0;
    logic sg;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.refill_addr_i = 20'h00300;
    bus.store_addr_i  = 20'h00300;
    bus.store_wdata_i = $urandom;
    bus.store_be_i    = 4'hF;
    bus.store_req_i   = 1'b1;
    bus.refill_req_i  = 1'b1;
    for (int cyc = 0; cyc < 400 && g < 8; cyc++) begin
      samp();
      sg = 1'b0;
      if (bus.store_gnt_o === 1'b1 && bus.refill_gnt_o === 1'b1) begin
        total++;
        bad++;
        $display("FAIL rr_both_gnt got=11 want=one");
      end
      if (bus.store_gnt_o === 1'b1) begin
        seq[g] = 1'b1;
        g++;
        ref_write(bus.store_addr_i, bus.store_wdata_i, bus.store_be_i);
        sg = 1'b1;
      end else if (bus.refill_gnt_o === 1'b1) begin
        seq[g] = 1'b0;
        g++;
        exp_q.push_back(exp_line(bus.refill_addr_i));
      end
      tick();
      if (sg) begin
        n++;
        bus.store_addr_i  = 20'h00300 + AW'(4 * (n % 4));
        bus.store_wdata_i = $urandom;
        bus.store_be_i    = 4'($urandom_range(0, 15));
      end
    end
    bus.store_req_i  = 1'b0;
    bus.refill_req_i = 1'b0;
    total++;
    if (g != 8) begin
      bad++;
      $display("FAIL rr_timeout grants=%0d want=8", g);
    end
    for (int i = 0; i < g; i++) begin
      total++;
      if (seq[i] !== ((i % 2) == 0)) begin
        bad++;
        $display("FAIL rr_order idx=%0d got_store=%b want_store=%b", i, seq[i], (i % 2) == 0);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    // store granted at T
    tick();
    bus.store_addr_i  = 20'h00500;
    bus.store_wdata_i = 32'hCAFEF00D;
    bus.store_be_i    = 4'hF;
    bus.store_req_i   = 1'b1;
    samp();
    total++;
    if (bus.store_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_st_gnt got=%b want=1", bus.store_gnt_o);
    end
    ref_write(20'h00500, 32'hCAFEF00D, 4'hF);
    tick();                       // T+1
    bus.store_req_i = 1'b0;
    tick();                       // T+2
    bus.refill_addr_i = 20'h00500;
    bus.refill_req_i  = 1'b1;
    samp();
    total++;
    if (bus.refill_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rf1_gnt got=%b want=1", bus.refill_gnt_o);
    end
    exp_q.push_back(exp_line(20'h00500));
    tick();                       // T+3, second refill held from here
    bus.refill_addr_i = 20'h00100;
    for (int c = 3; c <= 8; c++) begin
      samp();
      total++;
      if (bus.busy_o !== 1'b1 || bus.refill_gnt_o !== 1'b0) begin
        bad++;
        $display("FAIL b2b_busy cyc=T+%0d busy=%b gnt=%b want 1 0", c, bus.busy_o,
                 bus.refill_gnt_o);
      end
      tick();
    end
    samp();                       // T+9
    total++;
    if (bus.refill_gnt_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rf2_gnt gnt=%b busy=%b want 1 0", bus.refill_gnt_o, bus.busy_o);
    end
    exp_q.push_back(exp_line(20'h00100));
    tick();
    bus.refill_req_i = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0;
    logic        saw_valid = 1'b0;
    tick();
    bus.refill_addr_i = 20'h00340;
    bus.refill_req_i  = 1'b1;
    samp();
    total++;
    if (bus.refill_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL rm_gnt got=%b want=1", bus.refill_gnt_o);
    end
    w0 = ref_rd(18'h000D0);
    tick();                       // T+1
    bus.refill_req_i = 1'b0;
    tick();                       // T+2
    tick();                       // T+3
    rst = 1'b1;
    samp();
    total++;
    if (bus.refill_line_o[31:0] !== w0) begin
      bad++;
      $display("FAIL rm_word0 got=%h want=%h", bus.refill_line_o[31:0], w0);
    end
    tick();                       // T+4
    rst = 1'b0;
    samp();
    total++;
    if (bus.mem_en_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.refill_line_o !== 128'd0) begin
      bad++;
      $display("FAIL rm_abort en=%b busy=%b line=%h want 0 0 0", bus.mem_en_o, bus.busy_o,
               bus.refill_line_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.refill_valid_o !== 1'b0) saw_valid = 1'b1;
      tick();
      samp();
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_no_valid got=1 want=0");
    end
  endtask

  task automatic test_high_addr();
    logic [127:0] got;
    do_refill(20'hFFFF4, got);
    total++;
    if (got[127:96] !== 32'hA5A5FFFF || got[31:0] !== 32'hA5A6FFFC) begin
      bad++;
      $display("FAIL high_line w3=%h w0=%h want a5a5ffff a5a6fffc", got[127:96], got[31:0]);
    end
  endtask

  initial begin
    bus.refill_req_i  = 1'b0;
    bus.refill_addr_i = '0;
    bus.store_req_i   = 1'b0;
    bus.store_addr_i  = '0;
    bus.store_wdata_i = 32'd0;
    bus.store_be_i    = 4'd0;
    test_reset();
    test_refill();
    test_store();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_high_addr();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
Sequences the 32-bit data port (port B) of the shared instruction/data RAM on behalf of the data cache. It serves two requesters: 4-word line refills, which it assembles into a 128-bit line, and single-word write-through stores. It arbitrates between them round-robin and sits between the data cache and RAM port B. Port A (instruction fetch) is untouched.

Parameters:
ADDR_WIDTH, 20, byte-address width of RAM port B and of both request addresses.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
refill_req_i  input  1  line refill request; held with stable address until granted.
refill_addr_i  input  ADDR_WIDTH  refill byte address; bits [3:0] ignored.
refill_gnt_o  output  1  combinational; refill accepted this cycle.
refill_valid_o  output  1  one-cycle pulse; refill_line_o holds the completed line.
refill_line_o  output  128  word k at bits [32k+:32]; holds value until next completion.
store_req_i  input  1  store request; held with stable address/data/be until granted.
store_addr_i  input  ADDR_WIDTH  store byte address; bits [1:0] ignored.
store_wdata_i  input  32  store data.
store_be_i  input  4  store byte enables.
store_gnt_o  output  1  combinational; store accepted this cycle.
busy_o  output  1  high whenever state != IDLE.
mem_en_o  output  1  RAM port B enable.
mem_we_o  output  1  RAM port B write enable.
mem_addr_o  output  ADDR_WIDTH  RAM port B byte address, always word-aligned.
mem_wdata_o  output  32  RAM write data.
mem_be_o  output  4  RAM byte enables.
mem_rdata_i  input  32  RAM read data; valid the cycle after a read is issued (1-cycle registered latency).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, issue counter=0, refill_line_o=0, refill_valid_o=0.
  - Priority flag last_was_store=0, so store wins the first tie.
  - All mem_* outputs are 0 while in IDLE.
- States: IDLE, RD, CAP, DONE, WR.
- Arbitration (IDLE only; both gnt outputs are 0 in every other state):
  - Only one requester asserted: that requester is granted.
  - Both asserted: store is granted if last_was_store=0, otherwise refill.
  - Update last_was_store on every grant: 1 for a store grant, 0 for a refill grant.
  - A request dropped before grant has no effect.
- Refill, granted in cycle T:
  - Latch base = {refill_addr_i[W-1:4], 4'h0}.
  - RD, cycles T+1..T+4: mem_en_o=1, mem_we_o=0, mem_be_o=4'hF, mem_addr_o=base+4*k for k=0..3 (counter-driven).
  - Capture mem_rdata_i into line word k one cycle after its issue. Words 0..2 are captured during RD; word 3 is captured in CAP (T+5).
  - DONE (T+6): refill_valid_o=1, mem_en_o=0, next state IDLE.
  - In DONE, gnt outputs stay 0; the next grant is possible at T+7. Grant-to-valid latency is 6 cycles; back-to-back refill grants are 7 cycles apart.
  - base+12 never carries out of bits [3:0]; no wrap logic is needed.
  - refill_line_o changes only on capture edges of an active refill; it is otherwise stable.
- Store, granted in cycle T:
  - Latch {store_addr_i[W-1:2], 2'b00}, wdata and be.
  - WR (T+1): mem_en_o=1, mem_we_o=1, latched addr/wdata/be on the mem_* outputs.
  - T+2: IDLE; a new grant is possible in T+2.
  - be=4'h0 is still issued (en=1, we=1); no bytes change.
- mem_wdata_o=0 and mem_be_o=4'hF during reads. In IDLE/CAP/DONE, mem_en_o=0 and mem_we_o=0.
- Reset mid-operation: the operation is aborted. The next cycle is IDLE with mem_en_o=0 and busy_o=0; refill_valid_o is never pulsed for the aborted refill; refill_line_o=0.
- No request arriving while busy is lost; it stays pending (requester holds) until IDLE grants it.

Test Plan:
1. Preload words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x00100. Refill addr 0x00104 → gnt at T; reads to 0x100/0x104/0x108/0x10C in T+1..T+4; refill_valid_o only at T+6; refill_line_o=0x44444444_33333333_22222222_11111111.
2. Store addr 0x00209, wdata 0xDEADBEEF, be 4'b0011 → gnt at T; T+1 has en=1, we=1, addr 0x208, be 0011. A following refill of 0x200 returns word2[15:0]=0xBEEF with its upper half unchanged.
3. After reset, hold both requests high continuously → store granted first, then refill, then store, strictly alternating; neither requester starves.
4. Refill request arriving at T+2 of a store → granted at T+2. A second refill held high from T+3 → gnt exactly at T+9; busy_o high T+3..T+8.
5. Assert rst at T+3 of a refill → T+4 mem_en_o=0, busy_o=0, refill_line_o=0; no refill_valid_o pulse occurs.
6. Refill addr 0xFFFF4 → addresses 0xFFFF0, 0xFFFF4, 0xFFFF8, 0xFFFFC; no wrap, line correct.
